// File: rtl/parity_tx_encoder_if.sv
// rtl/parity_tx_encoder_if.sv - valid/ready/data stream bundle used on both sides of the encoder
interface parity_tx_encoder_if #(
  parameter int W = 64
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/parity_tx_encoder.sv
// rtl/parity_tx_encoder.sv - appends even/odd parity to each word through a 2-entry FIFO,
// with an armable parity-error injector and transfer counters
module parity_tx_encoder #(
  parameter int DWIDTH = 64,
  parameter int DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  cfg_parity_type,
  parity_tx_encoder_if.slave    in_if,
  parity_tx_encoder_if.master   out_if,
  input  logic                  inj_arm,
  input  logic                  inj_cont,
  input  logic [15:0]           inj_skip,
  input  logic                  inj_stop,
  output logic                  inj_busy,
  output logic                  inj_done,
  output logic [31:0]           word_count,
  output logic [15:0]           inj_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    INJECT = 2'd2,
    DONE   = 2'd3
  } inj_state_t;

  inj_state_t    state;
  logic [15:0]   skip_cnt;
  logic          mode_cont;

  logic [DWIDTH:0] mem [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;

  logic push;
  logic pop;
  logic flip;
  logic parity;

  // Gating with rst_n keeps in_ready low for the whole reset, not just after the first edge.
  assign in_if.ready  = rst_n && en && (count != 2'(DEPTH));
  assign out_if.valid = (count != 2'd0);
  assign out_if.data  = out_if.valid ? mem[rd_ptr] : '0;

  assign push = in_if.valid && in_if.ready;
  assign pop  = out_if.valid && out_if.ready;

  assign flip   = push && (((state == ARMED) && (skip_cnt == 16'd0)) || (state == INJECT));
  assign parity = (^in_if.data) ^ cfg_parity_type ^ flip;

  assign inj_busy = (state != IDLE);
  assign inj_done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {parity, in_if.data};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
      inj_count  <= '0;
    end else begin
      if (pop && (word_count != 32'hFFFF_FFFF)) begin
        word_count <= word_count + 32'd1;
      end
      if (flip) begin
        inj_count <= inj_count + 16'd1;
      end
    end
  end

  // A single-mode flip reaches DONE even if inj_stop lands on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      skip_cnt  <= 16'd0;
      mode_cont <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inj_arm) begin
            skip_cnt  <= inj_skip;
            mode_cont <= inj_cont;
            state     <= ARMED;
          end
        end
        ARMED: begin
          if (push && (skip_cnt == 16'd0) && !mode_cont) begin
            state <= DONE;
          end else if (inj_stop) begin
            state <= IDLE;
          end else if (push) begin
            if (skip_cnt != 16'd0) begin
              skip_cnt <= skip_cnt - 16'd1;
            end else begin
              state <= INJECT;
            end
          end
        end
        INJECT: begin
          if (inj_stop) begin
            state <= IDLE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_tx_encoder.sv
// tb/tb_parity_tx_encoder.sv - self-checking bench for parity_tx_encoder
module tb_parity_tx_encoder;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        cfg_parity_type;
  logic        inj_arm;
  logic        inj_cont;
  logic [15:0] inj_skip;
  logic        inj_stop;
  logic        inj_busy;
  logic        inj_done;
  logic [31:0] word_count;
  logic [15:0] inj_count;

  parity_tx_encoder_if #(.W(64)) in_if ();
  parity_tx_encoder_if #(.W(65)) out_if ();

  parity_tx_encoder #(.DWIDTH(64), .DEPTH(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .cfg_parity_type (cfg_parity_type),
    .in_if           (in_if),
    .out_if          (out_if),
    .inj_arm         (inj_arm),
    .inj_cont        (inj_cont),
    .inj_skip        (inj_skip),
    .inj_stop        (inj_stop),
    .inj_busy        (inj_busy),
    .inj_done        (inj_done),
    .word_count      (word_count),
    .inj_count       (inj_count)
  );

  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  logic [64:0] q[$];
  bit          m_active;
  bit          m_cont;
  bit          m_done;
  int          m_skip;
  int          m_idx;
  logic [31:0] exp_wc;
  logic [15:0] exp_ic;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_active = 0;
    m_cont   = 0;
    m_done   = 0;
    m_skip   = 0;
    m_idx    = 0;
    exp_wc   = '0;
    exp_ic   = '0;
  endtask

  // One clock: check outputs against the model, let the edge happen, then advance the model.
  task automatic cycle();
    bit          exp_rdy;
    bit          acc;
    bit          pop;
    bit          flip;
    bit          arm_ok;
    bit          p;
    logic [64:0] w;
    #1;
    exp_rdy = en && (q.size() < 2);
    chk("in_ready", in_if.ready, exp_rdy);
    chk("out_valid", out_if.valid, q.size() != 0);
    if (q.size() != 0) chk("out_bus", out_if.data, q[0]);
    chk("word_count", word_count, exp_wc);
    chk("inj_count", inj_count, exp_ic);
    chk("inj_busy", inj_busy, m_active || m_done);
    chk("inj_done", inj_done, m_done);
    acc    = in_if.valid && exp_rdy;
    pop    = (q.size() != 0) && out_if.ready;
    flip   = m_active && acc && (m_idx >= m_skip) && (m_cont || (m_idx == m_skip));
    arm_ok = inj_arm && !m_active && !m_done;
    p      = ($countones(in_if.data) % 2 == 1) ^ cfg_parity_type ^ flip;
    w      = {p, in_if.data};
    @(posedge clk);
    #1;
    m_done = 0;
    if (pop) begin
      void'(q.pop_front());
      if (exp_wc != 32'hFFFF_FFFF) exp_wc = exp_wc + 1;
    end
    if (acc) q.push_back(w);
    if (flip) exp_ic = exp_ic + 1;
    if (m_active && acc) m_idx++;
    if (flip && !m_cont) begin
      m_active = 0;
      m_done   = 1;
    end else if (inj_stop && m_active) begin
      m_active = 0;
    end
    if (arm_ok) begin
      m_active = 1;
      m_cont   = inj_cont;
      m_skip   = int'(inj_skip);
      m_idx    = 0;
    end
    inj_arm  = 0;
    inj_stop = 0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    clk             = 0;
    rst_n           = 0;
    en              = 1;
    cfg_parity_type = 0;
    inj_arm         = 0;
    inj_cont        = 0;
    inj_skip        = 0;
    inj_stop        = 0;
    in_if.valid     = 0;
    in_if.data      = '0;
    out_if.ready    = 1;
    model_clear();

    // reset state
    #1;
    chk("rst_out_valid", out_if.valid, 1'b0);
    chk("rst_out_bus", out_if.data, 65'd0);
    chk("rst_in_ready", in_if.ready, 1'b0);
    chk("rst_inj_busy", inj_busy, 1'b0);
    chk("rst_inj_done", inj_done, 1'b0);
    chk("rst_word_count", word_count, 32'd0);
    chk("rst_inj_count", inj_count, 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // even parity of 1 -> 1, one-cycle latency
    in_if.valid = 1; in_if.data = 64'h1; cfg_parity_type = 0;
    cycle();
    chk("even1_valid", out_if.valid, 1'b1);
    chk("even1_par", out_if.data[64], 1'b1);
    in_if.valid = 0;
    cycle();
    chk("even1_wc", word_count, 32'd1);

    // odd vs even parity of 3
    in_if.valid = 1; in_if.data = 64'h3; cfg_parity_type = 1;
    cycle();
    chk("odd3_par", out_if.data[64], 1'b1);
    cfg_parity_type = 0;
    cycle();
    chk("even3_par", out_if.data[64], 1'b0);
    in_if.valid = 0;
    cycle();
    cycle();

    // backpressure: fill, block, drain in order
    out_if.ready = 0; in_if.valid = 1;
    in_if.data = {$urandom, $urandom};
    cycle();
    in_if.data = {$urandom, $urandom};
    cycle();
    chk("full_in_ready", in_if.ready, 1'b0);
    in_if.data = {$urandom, $urandom};
    cycle();
    in_if.valid = 0; out_if.ready = 1;
    cycle();
    cycle();
    chk("drain_wc", word_count, 32'd5);
    chk("drain_empty", out_if.valid, 1'b0);

    // single-shot injection after skipping two words
    inj_arm = 1; inj_skip = 16'd2; inj_cont = 0;
    cycle();
    in_if.valid = 1;
    for (int i = 0; i < 5; i++) begin
      in_if.data = {$urandom, $urandom};
      cycle();
    end
    in_if.valid = 0;
    repeat (3) cycle();
    chk("single_inj_count", inj_count, 16'd1);
    chk("single_busy", inj_busy, 1'b0);

    // continuous injection, stopped after four words
    inj_arm = 1; inj_skip = 16'd0; inj_cont = 1;
    cycle();
    in_if.valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_if.data = {$urandom, $urandom};
      cycle();
    end
    in_if.valid = 0; inj_stop = 1;
    cycle();
    in_if.valid = 1;
    for (int i = 0; i < 2; i++) begin
      in_if.data = {$urandom, $urandom};
      cycle();
    end
    in_if.valid = 0;
    repeat (2) cycle();
    chk("cont_inj_count", inj_count, 16'd5);
    chk("cont_busy", inj_busy, 1'b0);

    // randomized traffic with random arms/stops
    for (int i = 0; i < 500; i++) begin
      en              = ($urandom_range(0, 7) != 0);
      cfg_parity_type = $urandom_range(0, 1);
      in_if.valid     = $urandom_range(0, 1);
      in_if.data      = {$urandom, $urandom};
      out_if.ready    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        inj_arm  = 1;
        inj_skip = 16'($urandom_range(0, 3));
        inj_cont = $urandom_range(0, 1);
      end
      if ($urandom_range(0, 14) == 0) inj_stop = 1;
      cycle();
    end

    // asynchronous reset with two buffered words and the injector armed
    en = 1; in_if.valid = 0; out_if.ready = 1;
    repeat (3) cycle();
    inj_arm = 1; inj_skip = 16'd10; inj_cont = 0;
    cycle();
    out_if.ready = 0; in_if.valid = 1;
    for (int i = 0; i < 2; i++) begin
      in_if.data = {$urandom, $urandom};
      cycle();
    end
    in_if.valid = 0;
    #2;
    rst_n = 0;
    #1;
    chk("arst_out_valid", out_if.valid, 1'b0);
    chk("arst_inj_busy", inj_busy, 1'b0);
    chk("arst_word_count", word_count, 32'd0);
    chk("arst_inj_count", inj_count, 16'd0);
    chk("arst_in_ready", in_if.ready, 1'b0);
    model_clear();
    @(negedge clk);
    rst_n = 1;
    out_if.ready = 1;
    @(posedge clk);
    #1;
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
